// File: rtl/pio_pkg.sv
// Shared definitions for the GPIO bank: configuration register select codes
// and synchroniser depth limits.
package pio_pkg;

  typedef enum logic [2:0] {
    OE      = 3'd0,
    RISE_EN = 3'd1,
    FALL_EN = 3'd2,
    MASK0   = 3'd3,
    MASK1   = 3'd4,
    CLEAR   = 3'd5
  } cfg_sel_e;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

endpackage

// File: rtl/pio_sync.sv
// Multi-bit flop-chain synchroniser for asynchronous pad inputs; each bit is
// synchronised independently, no cross-bit coherence is implied.
module pio_sync #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [STAGES-1:0][DATA_W-1:0] chain_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d};
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pio_irq.sv
// GPIO bank: registered pad outputs/enables, synchronised pad inputs and
// per-bit edge interrupts with sticky pending bits and two masked irq lines.
module pio_irq
  import pio_pkg::*;
#(
  parameter int                   dataWidth     = 32,
  parameter int                   syncStages    = 2,
  parameter logic [dataWidth-1:0] outResetValue = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [dataWidth-1:0] in_wdata,
  input  logic [dataWidth-1:0] in_wenable,
  output logic [dataWidth-1:0] in_rdata,
  input  logic [2:0]           cfg_sel,
  input  logic [dataWidth-1:0] cfg_wdata,
  input  logic                 cfg_we,
  output logic [dataWidth-1:0] irq_pending,
  output logic [dataWidth-1:0] out_wdata,
  output logic [dataWidth-1:0] out_wenable,
  input  logic [dataWidth-1:0] out_rdata,
  output logic                 irq0,
  output logic                 irq1
);

  if (syncStages < SYNC_MIN || syncStages > SYNC_MAX) begin : g_bad_sync
    $error("pio_irq: syncStages must lie in 2..4");
  end

  logic [dataWidth-1:0] out_q, out_d;
  logic [dataWidth-1:0] oe_q, oe_d;
  logic [dataWidth-1:0] rise_en_q, rise_en_d;
  logic [dataWidth-1:0] fall_en_q, fall_en_d;
  logic [dataWidth-1:0] mask0_q, mask0_d;
  logic [dataWidth-1:0] mask1_q, mask1_d;
  logic [dataWidth-1:0] pend_q, pend_d;
  logic [dataWidth-1:0] prev_q;
  logic [dataWidth-1:0] clear;
  logic [dataWidth-1:0] edge_set;

  pio_sync #(
    .DATA_W (dataWidth),
    .STAGES (syncStages)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (out_rdata),
    .q       (in_rdata)
  );

  always_comb begin
    out_d     = (out_q & ~in_wenable) | (in_wdata & in_wenable);
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    mask0_d   = mask0_q;
    mask1_d   = mask1_q;
    clear     = '0;
    if (cfg_we) begin
      case (cfg_sel)
        OE:      oe_d      = cfg_wdata;
        RISE_EN: rise_en_d = cfg_wdata;
        FALL_EN: fall_en_d = cfg_wdata;
        MASK0:   mask0_d   = cfg_wdata;
        MASK1:   mask1_d   = cfg_wdata;
        CLEAR:   clear     = cfg_wdata;
        default: ;
      endcase
    end
    edge_set = (in_rdata & ~prev_q & rise_en_q) | (~in_rdata & prev_q & fall_en_q);
    // A new edge outranks a simultaneous write-1-to-clear on the same bit.
    pend_d   = (pend_q & ~clear) | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= outResetValue;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      mask0_q   <= '0;
      mask1_q   <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      mask0_q   <= mask0_d;
      mask1_q   <= mask1_d;
      pend_q    <= pend_d;
      prev_q    <= in_rdata;
    end
  end

  assign out_wdata   = out_q;
  assign out_wenable = oe_q;
  assign irq_pending = pend_q;
  assign irq0        = |(pend_q & mask0_q);
  assign irq1        = |(pend_q & mask1_q);

endmodule

// File: tb/tb_pio_irq.sv
// Bench for pio_irq: two builds (2- and 3-stage synchroniser) share stimulus
// and are compared every cycle against a pad-history based reference model.
module tb_pio_irq;
  import pio_pkg::*;

  localparam int W = 32;
  localparam logic [W-1:0] RST_OUT = 32'hA5A5_0000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in_wdata = '0, in_wenable = '0, cfg_wdata = '0, out_rdata = '0;
  logic [2:0]   cfg_sel = 3'd0;
  logic         cfg_we = 1'b0;

  logic [W-1:0] in_rdata2, pend2, outw2, oe2;
  logic [W-1:0] in_rdata3, pend3, outw3, oe3;
  logic         irq0_2, irq1_2, irq0_3, irq1_3;

  int  n_chk = 0;
  int  n_pass = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  pio_irq #(.dataWidth(W), .syncStages(2), .outResetValue(RST_OUT)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_wdata(in_wdata), .in_wenable(in_wenable),
    .in_rdata(in_rdata2), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we),
    .irq_pending(pend2), .out_wdata(outw2), .out_wenable(oe2), .out_rdata(out_rdata),
    .irq0(irq0_2), .irq1(irq1_2));

  pio_irq #(.dataWidth(W), .syncStages(3), .outResetValue(RST_OUT)) dut3 (
    .clk(clk), .reset_n(reset_n), .in_wdata(in_wdata), .in_wenable(in_wenable),
    .in_rdata(in_rdata3), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we),
    .irq_pending(pend3), .out_wdata(outw3), .out_wenable(oe3), .out_rdata(out_rdata),
    .irq0(irq0_3), .irq1(irq1_3));

  // Reference model: hist[j] is the pad value sampled j+1 edges ago, so a
  // build with S stages shows hist[S-1] and its previous value is hist[S].
  logic [W-1:0] m_out, m_oe, m_rise, m_fall, m_mask0, m_mask1;
  logic [W-1:0] m_pend [2];
  logic [W-1:0] hist [6];

  task automatic model_reset();
    m_out = RST_OUT; m_oe = '0; m_rise = '0; m_fall = '0; m_mask0 = '0; m_mask1 = '0;
    m_pend[0] = '0; m_pend[1] = '0;
    for (int i = 0; i < 6; i++) hist[i] = '0;
  endtask

  always @(negedge reset_n) model_reset();

  always @(posedge clk) begin : mdl
    logic [W-1:0] clr, cur, prv;
    if (reset_n) begin
      clr = (cfg_we && cfg_sel == 3'd5) ? cfg_wdata : '0;
      for (int k = 0; k < 2; k++) begin
        cur = hist[k+1];
        prv = hist[k+2];
        m_pend[k] = (m_pend[k] & ~clr) | (cur & ~prv & m_rise) | (~cur & prv & m_fall);
      end
      for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = out_rdata;
      m_out = (m_out & ~in_wenable) | (in_wdata & in_wenable);
      if (cfg_we) begin
        case (cfg_sel)
          3'd0: m_oe = cfg_wdata;
          3'd1: m_rise = cfg_wdata;
          3'd2: m_fall = cfg_wdata;
          3'd3: m_mask0 = cfg_wdata;
          3'd4: m_mask1 = cfg_wdata;
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_wdata/2", outw2, m_out);
      chk("out_wdata/3", outw3, m_out);
      chk("out_wenable/2", oe2, m_oe);
      chk("out_wenable/3", oe3, m_oe);
      chk("in_rdata/2", in_rdata2, hist[1]);
      chk("in_rdata/3", in_rdata3, hist[2]);
      chk("irq_pending/2", pend2, m_pend[0]);
      chk("irq_pending/3", pend3, m_pend[1]);
      chk("irq0/2", W'(irq0_2), W'(|(m_pend[0] & m_mask0)));
      chk("irq1/2", W'(irq1_2), W'(|(m_pend[0] & m_mask1)));
      chk("irq0/3", W'(irq0_3), W'(|(m_pend[1] & m_mask0)));
      chk("irq1/3", W'(irq1_3), W'(|(m_pend[1] & m_mask1)));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [W-1:0] data);
    cfg_sel = sel; cfg_wdata = data; cfg_we = 1'b1;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    chk_en = 1'b1;
    cyc(2);
    chk("reset out_wdata", outw2, 32'hA5A5_0000);
    chk("reset out_wenable", oe2, 32'h0);
    chk("reset in_rdata", in_rdata2, 32'h0);
    chk("reset irq_pending", pend2, 32'h0);
    chk("reset irq0/irq1", W'({irq0_2, irq1_2}), 32'h0);
    reset_n = 1'b1;

    in_wenable = '1; in_wdata = '1;
    cyc();
    in_wenable = 32'h0000_FFFF; in_wdata = 32'h1234_5678;
    cyc();
    in_wenable = '0;
    chk("strobed write", outw2, 32'hFFFF_5678);
    cfg_write(3'd0, 32'hF0);
    chk("OE write", oe2, 32'hF0);

    cfg_write(3'd1, 32'h8);
    cfg_write(3'd3, 32'h8);
    out_rdata[3] = 1'b1;
    cyc();
    chk("rise in_rdata after 1", W'(in_rdata2[3]), 32'h0);
    cyc();
    chk("rise in_rdata after 2", W'(in_rdata2[3]), 32'h1);
    chk("rise pending after 2", W'(pend2[3]), 32'h0);
    cyc();
    chk("rise pending after 3", W'(pend2[3]), 32'h1);
    chk("rise irq0", W'(irq0_2), 32'h1);
    chk("rise irq1", W'(irq1_2), 32'h0);
    chk("sync3 pending after 3", W'(pend3[3]), 32'h0);
    cyc();
    chk("sync3 pending after 4", W'(pend3[3]), 32'h1);
    cfg_write(3'd5, 32'h8);
    chk("clear bit3", pend2, 32'h0);

    cfg_write(3'd2, 32'h1);
    cfg_write(3'd4, 32'h1);
    out_rdata[0] = 1'b1;
    cyc(4);
    chk("no capture on rise", pend2, 32'h0);
    out_rdata[0] = 1'b0;
    cyc(2);
    chk("fall pending after 2", pend2, 32'h0);
    cyc();
    chk("fall pending after 3", pend2, 32'h1);
    chk("fall irq1", W'(irq1_2), 32'h1);
    cyc();
    cfg_write(3'd5, 32'h1);
    chk("clear bit0", pend2, 32'h0);
    chk("clear irq1", W'(irq1_2), 32'h0);

    cfg_write(3'd1, 32'h28);
    out_rdata[5] = 1'b1;
    cyc(2);
    cfg_write(3'd5, 32'h20);
    chk("set beats clear", W'(pend2[5]), 32'h1);
    cyc();
    cfg_write(3'd5, 32'h20);
    chk("clear bit5", pend2, 32'h0);

    cfg_write(3'd1, 32'h200);
    cfg_write(3'd2, 32'h200);
    for (int i = 0; i < 12; i++) begin
      out_rdata[9] = ~out_rdata[9];
      cyc();
    end

    cfg_write(3'd2, 32'h0);
    cfg_write(3'd1, 32'hFF);
    out_rdata = '0;
    cyc(4);
    cfg_write(3'd5, '1);
    out_rdata = 32'hFF;
    cyc(4);
    chk("pending FF/2", pend2, 32'hFF);
    chk("pending FF/3", pend3, 32'hFF);
    cfg_write(3'd3, '1);
    chk("irq0 before reset", W'(irq0_2), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset pending", pend2, 32'h0);
    chk("async reset irq0", W'(irq0_2), 32'h0);
    chk("async reset out_wdata", outw2, 32'hA5A5_0000);
    chk("async reset in_rdata", in_rdata2, 32'h0);
    cyc();
    reset_n = 1'b1;

    for (int n = 0; n < 600; n++) begin
      in_wenable = $urandom;
      in_wdata   = $urandom;
      if ($urandom_range(0, 1) == 0) out_rdata = out_rdata ^ $urandom;
      cfg_we    = ($urandom_range(0, 3) == 0);
      cfg_sel   = 3'($urandom_range(0, 7));
      cfg_wdata = $urandom;
      if (n == 300) begin
        #2 reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
      end
      cyc();
    end
    cfg_we = 1'b0;
    cyc(2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
